// File: rtl/ee354_matrix_pkg.sv
// Shared definitions for the matrix entry controller: controller states
// and the row-major element index helper.
package ee354_matrix_pkg;

  typedef enum logic [1:0] {
    ENTER = 2'd0,
    HOLD  = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Row-major linear position of element (r, c) in an n x n matrix.
  function automatic int idx(input int r, input int c, input int n);
    return r * n + c;
  endfunction

endpackage

// File: rtl/ee354_matrix_entry_ctrl_if.sv
// Matrix hand-off bus between the entry controller (master) and the
// arithmetic core (slave): flat matrix, valid/ready and the done flag.
interface ee354_matrix_entry_ctrl_if #(
  parameter int N = 4,
  parameter int W = 4
);

  logic [N*N*W-1:0] mat_flat;
  logic             mat_valid;
  logic             mat_ready;
  logic             core_done;

  modport master (
    output mat_flat,
    output mat_valid,
    input  mat_ready,
    input  core_done
  );

  modport slave (
    input  mat_flat,
    input  mat_valid,
    output mat_ready,
    output core_done
  );

endinterface

// File: rtl/ee354_matrix_cursor.sv
// Row/column cursor for sequential entry: walks the matrix row-major,
// wraps from the last element back to (0,0), and can be cleared at once.
module ee354_matrix_cursor #(
  parameter  int N  = 4,
  localparam int AW = $clog2(N)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          clear,
  input  logic          advance,
  output logic [AW-1:0] row,
  output logic [AW-1:0] col
);

  // Cursor register: clear has priority over advance; advance carries
  // from the last column into the next row and wraps after the last row.
  always_ff @(posedge Clk) begin
    if (Reset || clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col == AW'(N - 1)) begin
        col <= '0;
        row <= (row == AW'(N - 1)) ? '0 : row + AW'(1);
      end else begin
        col <= col + AW'(1);
      end
    end
  end

endmodule

// File: rtl/ee354_matrix_entry_ctrl.sv
// N x N matrix entry buffer and hand-off controller. Elements are entered
// by explicit row/column or through an auto-incrementing cursor, then the
// whole matrix is offered to the core and held frozen until the result is
// acknowledged.
module ee354_matrix_entry_ctrl
  import ee354_matrix_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 4,
  localparam int AW = $clog2(N),
  localparam int CW = $clog2(N*N + 1)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Enter,
  input  logic          Start,
  input  logic          Ack,
  input  logic          Clear,
  input  logic          AutoMode,
  input  logic [AW-1:0] Row,
  input  logic [AW-1:0] Col,
  input  logic [W-1:0]  Data,
  ee354_matrix_entry_ctrl_if.master core_bus,
  output logic [AW-1:0] cur_row,
  output logic [AW-1:0] cur_col,
  output logic [W-1:0]  cur_data,
  output logic [CW-1:0] wr_count,
  output logic          all_written,
  output logic          addr_err,
  output logic          q_Enter,
  output logic          q_Hold,
  output logic          q_Busy,
  output logic          q_Done
);

  localparam int NE = N * N;
  localparam int IW = $clog2(NE);

  state_t          state_q;
  state_t          state_d;
  logic [W-1:0]    mem [NE];
  logic [NE-1:0]   written;
  logic [CW-1:0]   count_q;
  logic            err_q;
  logic [AW-1:0]   cursor_row;
  logic [AW-1:0]   cursor_col;
  logic [AW-1:0]   tgt_row;
  logic [AW-1:0]   tgt_col;
  logic            tgt_in_range;
  logic [IW-1:0]   tgt_idx;
  logic            in_enter;
  logic            do_clear;
  logic            do_write;
  logic            cursor_clear;

  assign tgt_row      = AutoMode ? cursor_row : Row;
  assign tgt_col      = AutoMode ? cursor_col : Col;
  assign tgt_in_range = (int'(tgt_row) < N) && (int'(tgt_col) < N);
  assign tgt_idx      = IW'(idx(int'(tgt_row), int'(tgt_col), N));

  // Clear beats a same-cycle Enter; both only count while in ENTER.
  assign in_enter     = (state_q == ENTER);
  assign do_clear     = in_enter && Clear;
  assign do_write     = in_enter && Enter && !Clear && tgt_in_range;
  assign cursor_clear = do_clear || ((state_q == DONE) && Ack);

  ee354_matrix_cursor #(.N(N)) u_cursor (
    .Clk     (Clk),
    .Reset   (Reset),
    .clear   (cursor_clear),
    .advance (do_write && AutoMode),
    .row     (cursor_row),
    .col     (cursor_col)
  );

  // Element storage, written-bitmap, distinct-write counter and the
  // one-cycle address error flag.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NE; i++) mem[i] <= '0;
      written <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= in_enter && Enter && !Clear && !tgt_in_range;
      if (do_clear) begin
        for (int i = 0; i < NE; i++) mem[i] <= '0;
        written <= '0;
        count_q <= '0;
      end else if (do_write) begin
        mem[tgt_idx]     <= Data;
        written[tgt_idx] <= 1'b1;
        if (!written[tgt_idx]) count_q <= count_q + CW'(1);
      end
    end
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= ENTER;
    else       state_q <= state_d;
  end

  // Next-state logic for the entry / offer / compute / result cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ENTER:   if (Start)              state_d = HOLD;
      HOLD:    if (core_bus.mat_ready) state_d = BUSY;
      BUSY:    if (core_bus.core_done) state_d = DONE;
      DONE:    if (Ack)                state_d = ENTER;
      default:                         state_d = ENTER;
    endcase
  end

  for (genvar g = 0; g < NE; g++) begin : g_pack
    assign core_bus.mat_flat[g*W +: W] = mem[g];
  end

  assign core_bus.mat_valid = (state_q == HOLD);
  assign cur_row     = tgt_row;
  assign cur_col     = tgt_col;
  assign cur_data    = tgt_in_range ? mem[tgt_idx] : '0;
  assign wr_count    = count_q;
  assign all_written = (count_q == CW'(NE));
  assign addr_err    = err_q;
  assign q_Enter     = (state_q == ENTER);
  assign q_Hold      = (state_q == HOLD);
  assign q_Busy      = (state_q == BUSY);
  assign q_Done      = (state_q == DONE);

endmodule

// File: tb/tb_ee354_matrix_entry_ctrl.sv
// Bench for the matrix entry controller: an N=4 and an N=3 instance share
// the same stimulus and are compared every cycle against a matrix model.
module tb_ee354_matrix_entry_ctrl;

  logic       Clk = 1'b0;
  logic       Reset, Enter, Start, Ack, Clear, AutoMode;
  logic [1:0] Row, Col;
  logic [3:0] Data;
  logic       mat_ready, core_done;

  int vecCount  = 0;
  int failCount = 0;

  // model state, index 0 = N=4 instance, index 1 = N=3 instance
  int m_mem [2][64];
  bit m_bm  [2][64];
  int m_r [2];
  int m_c [2];
  int m_st[2];
  bit m_err[2];

  logic [1:0] cr4, cc4, cr3, cc3;
  logic [3:0] cd4, cd3, wc3;
  logic [4:0] wc4;
  logic       aw4, aw3, ae4, ae3;
  logic       qe4, qh4, qb4, qd4, qe3, qh3, qb3, qd3;

  ee354_matrix_entry_ctrl_if #(.N(4), .W(4)) bus4 ();
  ee354_matrix_entry_ctrl_if #(.N(3), .W(4)) bus3 ();

  assign bus4.mat_ready = mat_ready;
  assign bus4.core_done = core_done;
  assign bus3.mat_ready = mat_ready;
  assign bus3.core_done = core_done;

  // 100 MHz-style free-running clock.
  always #5 Clk = ~Clk;

  ee354_matrix_entry_ctrl #(.N(4), .W(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .Enter(Enter), .Start(Start), .Ack(Ack),
    .Clear(Clear), .AutoMode(AutoMode), .Row(Row), .Col(Col), .Data(Data),
    .core_bus(bus4), .cur_row(cr4), .cur_col(cc4), .cur_data(cd4),
    .wr_count(wc4), .all_written(aw4), .addr_err(ae4),
    .q_Enter(qe4), .q_Hold(qh4), .q_Busy(qb4), .q_Done(qd4)
  );

  ee354_matrix_entry_ctrl #(.N(3), .W(4)) dut3 (
    .Clk(Clk), .Reset(Reset), .Enter(Enter), .Start(Start), .Ack(Ack),
    .Clear(Clear), .AutoMode(AutoMode), .Row(Row), .Col(Col), .Data(Data),
    .core_bus(bus3), .cur_row(cr3), .cur_col(cc3), .cur_data(cd3),
    .wr_count(wc3), .all_written(aw3), .addr_err(ae3),
    .q_Enter(qe3), .q_Hold(qh3), .q_Busy(qb3), .q_Done(qd3)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vecCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Advance the model of instance k (dimension n) across one clock edge.
  task automatic modelStep(input int k, input int n);
    int tr, tc, lin;
    if (Reset) begin
      for (int i = 0; i < 64; i++) begin m_mem[k][i] = 0; m_bm[k][i] = 0; end
      m_r[k] = 0; m_c[k] = 0; m_st[k] = 0; m_err[k] = 0;
      return;
    end
    m_err[k] = 0;
    case (m_st[k])
      0: begin
        if (Clear) begin
          for (int i = 0; i < 64; i++) begin m_mem[k][i] = 0; m_bm[k][i] = 0; end
          m_r[k] = 0; m_c[k] = 0;
        end else if (Enter) begin
          tr = AutoMode ? m_r[k] : int'(Row);
          tc = AutoMode ? m_c[k] : int'(Col);
          if (tr < n && tc < n) begin
            m_mem[k][tr*n+tc] = int'(Data);
            m_bm[k][tr*n+tc]  = 1;
            if (AutoMode) begin
              lin = (tr * n + tc + 1) % (n * n);
              m_r[k] = lin / n;
              m_c[k] = lin % n;
            end
          end else begin
            m_err[k] = 1;
          end
        end
        if (Start) m_st[k] = 1;
      end
      1: if (mat_ready) m_st[k] = 2;
      2: if (core_done) m_st[k] = 3;
      default: if (Ack) begin m_st[k] = 0; m_r[k] = 0; m_c[k] = 0; end
    endcase
  endtask

  // Compare every output of one instance with the model.
  task automatic checkInst(input int k, input int n, input logic [63:0] flat,
                           input logic valid, input logic [3:0] q,
                           input logic [1:0] cr, input logic [1:0] cc,
                           input logic [3:0] cd, input logic [4:0] wc,
                           input logic aw, input logic ae);
    logic [63:0] eflat;
    int tr, tc, cnt, ed;
    eflat = '0;
    cnt = 0;
    for (int i = 0; i < n * n; i++) begin
      eflat[i*4 +: 4] = 4'(m_mem[k][i]);
      if (m_bm[k][i]) cnt++;
    end
    tr = AutoMode ? m_r[k] : int'(Row);
    tc = AutoMode ? m_c[k] : int'(Col);
    ed = (tr < n && tc < n) ? m_mem[k][tr*n+tc] : 0;
    checkOutput($sformatf("n%0d_flat", n), flat, eflat);
    checkOutput($sformatf("n%0d_valid", n), 64'(valid), 64'(m_st[k] == 1));
    checkOutput($sformatf("n%0d_state", n), 64'(q), 64'(4'b1000 >> m_st[k]));
    checkOutput($sformatf("n%0d_cur_row", n), 64'(cr), 64'(tr));
    checkOutput($sformatf("n%0d_cur_col", n), 64'(cc), 64'(tc));
    checkOutput($sformatf("n%0d_cur_data", n), 64'(cd), 64'(ed));
    checkOutput($sformatf("n%0d_wr_count", n), 64'(wc), 64'(cnt));
    checkOutput($sformatf("n%0d_all_written", n), 64'(aw), 64'(cnt == n * n));
    checkOutput($sformatf("n%0d_addr_err", n), 64'(ae), 64'(m_err[k]));
  endtask

  // One clock: model both instances, check after the edge, drop pulses.
  task automatic applyStimulus();
    @(posedge Clk);
    modelStep(0, 4);
    modelStep(1, 3);
    #1;
    checkInst(0, 4, 64'(bus4.mat_flat), bus4.mat_valid, {qe4, qh4, qb4, qd4},
              cr4, cc4, cd4, wc4, aw4, ae4);
    checkInst(1, 3, 64'(bus3.mat_flat), bus3.mat_valid, {qe3, qh3, qb3, qd3},
              cr3, cc3, cd3, 5'(wc3), aw3, ae3);
    @(negedge Clk);
    Reset = 0; Enter = 0; Start = 0; Ack = 0; Clear = 0;
    mat_ready = 0; core_done = 0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus();
  endtask

  task automatic fillAuto();
    AutoMode = 1;
    for (int i = 1; i <= 16; i++) begin
      Enter = 1; Data = 4'(i); applyStimulus();
    end
  endtask

  logic [35:0] saved3;

  // Directed scenarios followed by randomized traffic.
  initial begin
    Reset = 1; Enter = 0; Start = 0; Ack = 0; Clear = 0; AutoMode = 0;
    Row = 0; Col = 0; Data = 0; mat_ready = 0; core_done = 0;
    applyStimulus();
    Reset = 1; applyStimulus();

    fillAuto();
    checkOutput("seq16_flat", bus4.mat_flat, 64'h0FED_CBA9_8765_4321);
    checkOutput("seq16_count", 64'(wc4), 64'd16);
    checkOutput("seq16_all", 64'(aw4), 64'd1);
    checkOutput("seq16_cursor", 64'({cr4, cc4}), 64'd0);

    Clear = 1; Enter = 1; Data = 4'hA; applyStimulus();
    checkOutput("clr_enter_flat", bus4.mat_flat, 64'd0);
    checkOutput("clr_enter_count", 64'(wc4), 64'd0);

    AutoMode = 0; Row = 2; Col = 3; Data = 7; Enter = 1; applyStimulus();
    Data = 9; Enter = 1; applyStimulus();
    checkOutput("rewrite_elem11", 64'(bus4.mat_flat[44 +: 4]), 64'd9);
    checkOutput("rewrite_count", 64'(wc4), 64'd1);

    saved3 = bus3.mat_flat;
    Row = 3; Col = 0; Data = 5; Enter = 1; applyStimulus();
    checkOutput("n3_row3_err", 64'(ae3), 64'd1);
    checkOutput("n3_row3_flat", 64'(bus3.mat_flat), 64'(saved3));
    applyStimulus();
    checkOutput("n3_err_clears", 64'(ae3), 64'd0);

    Row = 1; Col = 1; Data = 4'hC; Enter = 1; Start = 1; applyStimulus();
    checkOutput("start_valid", 64'(bus4.mat_valid), 64'd1);
    checkOutput("start_elem5", 64'(bus4.mat_flat[20 +: 4]), 64'hC);
    for (int i = 0; i < 5; i++) begin
      Enter = 1; Clear = (i == 2); Data = 4'(i); Row = 0; Col = 0; applyStimulus();
    end
    mat_ready = 1; applyStimulus();
    idle(2);
    core_done = 1; applyStimulus();
    Ack = 1; applyStimulus();
    checkOutput("ack_retained", 64'(bus4.mat_flat[20 +: 4]), 64'hC);

    fillAuto();
    Start = 1; applyStimulus();
    mat_ready = 1; applyStimulus();
    Reset = 1; applyStimulus();
    checkOutput("busy_reset_q", 64'(qe4), 64'd1);
    checkOutput("busy_reset_flat", bus4.mat_flat, 64'd0);
    checkOutput("busy_reset_count", 64'(wc4), 64'd0);

    for (int i = 0; i < 800; i++) begin
      Reset     = ($urandom_range(0, 79) == 0);
      Enter     = ($urandom_range(0, 1) == 1);
      Start     = ($urandom_range(0, 9) == 0);
      Ack       = ($urandom_range(0, 3) == 0);
      Clear     = ($urandom_range(0, 19) == 0);
      AutoMode  = ($urandom_range(0, 2) != 0);
      Row       = 2'($urandom_range(0, 3));
      Col       = 2'($urandom_range(0, 3));
      Data      = 4'($urandom_range(0, 15));
      mat_ready = ($urandom_range(0, 2) == 0);
      core_done = ($urandom_range(0, 2) == 0);
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
    $finish;
  end

endmodule
